// File: rtl/proj_lane_gen_chk.sv
// rtl/proj_lane_gen_chk.sv - multi-pattern traffic generator/checker lane
// Optional random stall injection enabled by defining PROJ_LANE_GEN_CHK_STALL_EN.
module proj_lane_gen_chk #(
    parameter int W = 16,
    parameter int CW = 16,
    parameter int EW = 8,
    parameter int X = 1,
    parameter logic [W-1:0] SEED = W'(16'hACE1),
    parameter int TO = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic [1:0]    mode,
    input  logic [CW-1:0] len,
    output logic [W-1:0]  wrdata,
    output logic          wrvld,
    input  logic          wrrdy,
    input  logic [W-1:0]  rddata,
    input  logic          rdvld,
    output logic          rdrdy,
    output logic          busy,
    output logic          done,
    output logic          tmo,
    output logic [EW-1:0] errcntr,
    output logic          errflg,
    output logic [W-1:0]  errexp,
    output logic [W-1:0]  erract
);

    // Galois feedback masks (polynomial terms below x^W) of maximal-length LFSRs
    function automatic logic [31:0] poly_for(input int n);
        case (n)
            2:       return 32'h0000_0003;
            3:       return 32'h0000_0005;
            4:       return 32'h0000_0009;
            5:       return 32'h0000_0009;
            6:       return 32'h0000_0021;
            7:       return 32'h0000_0041;
            8:       return 32'h0000_0071;
            9:       return 32'h0000_0011;
            10:      return 32'h0000_0081;
            11:      return 32'h0000_0201;
            12:      return 32'h0000_0053;
            13:      return 32'h0000_001B;
            14:      return 32'h0000_002B;
            15:      return 32'h0000_4001;
            16:      return 32'h0000_A011;
            17:      return 32'h0000_4001;
            18:      return 32'h0000_0801;
            20:      return 32'h0002_0001;
            24:      return 32'h00C2_0001;
            32:      return 32'h0040_0007;
            default: return 32'h0000_0003;
        endcase
    endfunction

    localparam logic [W-1:0] POLY    = W'(poly_for(W));
    localparam logic [W-1:0] SEED_NZ = (SEED == '0) ? W'(1) : SEED;
    localparam int           TW      = $clog2(TO + 1);

    function automatic logic [W-1:0] pat_seed(input logic [1:0] m);
        case (m)
            2'd1:    return SEED_NZ;
            2'd2:    return W'(1);
            default: return '0;
        endcase
    endfunction

    function automatic logic [W-1:0] pat_next(input logic [1:0] m, input logic [W-1:0] v);
        case (m)
            2'd1:    return {v[W-2:0], 1'b0} ^ (v[W-1] ? POLY : '0);
            2'd2:    return {v[W-2:0], v[W-1]};
            default: return v + W'(X);
        endcase
    endfunction

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t        state, state_nx;
    logic [1:0]    md;
    logic [CW-1:0] ln;
    logic [W-1:0]  gen, chk;
    logic [CW-1:0] sent, rcvd;
    logic [TW-1:0] to_cnt;
    logic          go, wr_hs, rd_hs, last, phantom, mis, tmo_hit, drained;
    logic          gap_w, gap_r;

`ifdef PROJ_LANE_GEN_CHK_STALL_EN
    logic [15:0] stl;
    logic        presented;

    // Stall LFSR free-runs; presented keeps an offered word from being withdrawn
    always_ff @(posedge clk) begin
        if (rst || go) begin
            stl       <= 16'hACE1;
            presented <= 1'b0;
        end else begin
            stl       <= {stl[14:0], 1'b0} ^ (stl[15] ? 16'hA011 : 16'h0000);
            presented <= wrvld && !wrrdy;
        end
    end

    assign gap_w = (stl[1:0] == 2'b00) && !presented;
    assign gap_r = (stl[3:2] == 2'b00);
`else
    assign gap_w = 1'b0;
    assign gap_r = 1'b0;
`endif

    assign go      = start && (state == S_IDLE || state == S_DONE);
    assign wr_hs   = wrvld && wrrdy;
    assign rd_hs   = rdvld && rdrdy;
    assign last    = wr_hs && (ln != '0) && ((sent + CW'(1)) == ln);
    // A read beat with nothing outstanding (counting this cycle's write) is a phantom
    assign phantom = (rcvd == sent) && !wr_hs;
    assign mis     = rd_hs && (phantom || (rddata != chk));
    assign drained = (rcvd == sent);
    assign tmo_hit = !rd_hs && rdrdy && (to_cnt == TW'(TO - 1));

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nx = S_RUN;
            S_RUN:          if (stop || last) state_nx = S_DRAIN;
            S_DRAIN:        if (drained || tmo_hit) state_nx = S_DONE;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        wrvld  = (state == S_RUN) && !gap_w;
        rdrdy  = (state == S_RUN || state == S_DRAIN) && !gap_r;
        busy   = (state == S_RUN || state == S_DRAIN);
        done   = (state == S_DONE);
        wrdata = gen;
        errflg = (errcntr != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            md      <= 2'd0;
            ln      <= '0;
            gen     <= '0;
            chk     <= '0;
            sent    <= '0;
            rcvd    <= '0;
            to_cnt  <= '0;
            errcntr <= '0;
            errexp  <= '0;
            erract  <= '0;
            tmo     <= 1'b0;
        end else if (go) begin
            md      <= mode;
            ln      <= len;
            gen     <= pat_seed(mode);
            chk     <= pat_seed(mode);
            sent    <= '0;
            rcvd    <= '0;
            to_cnt  <= '0;
            errcntr <= '0;
            errexp  <= '0;
            erract  <= '0;
            tmo     <= 1'b0;
        end else begin
            if (wr_hs) begin
                gen  <= pat_next(md, gen);
                sent <= sent + CW'(1);
            end
            if (rd_hs) begin
                chk  <= pat_next(md, chk);
                rcvd <= rcvd + CW'(1);
            end
            if (mis) begin
                if (errcntr != '1) errcntr <= errcntr + EW'(1);
                if (errcntr == '0) begin
                    errexp <= chk;
                    erract <= rddata;
                end
            end
            if (state != S_DRAIN || rd_hs) to_cnt <= '0;
            else if (rdrdy)                to_cnt <= to_cnt + TW'(1);
            if (state == S_DRAIN && !drained && tmo_hit) tmo <= 1'b1;
        end
    end

endmodule

// File: tb/tb_proj_lane_gen_chk.sv
// tb/tb_proj_lane_gen_chk.sv - scoreboard bench for proj_lane_gen_chk with a wire-style DUT model
module tb_proj_lane_gen_chk;
    localparam int W  = 4;
    localparam int CW = 16;
    localparam int EW = 2;
    localparam int TO = 256;

    logic          clk = 1'b0;
    logic          rst, start, stop;
    logic [1:0]    mode;
    logic [CW-1:0] len;
    logic [W-1:0]  wrdata, rddata, errexp, erract;
    logic          wrvld, wrrdy, rdvld, rdrdy, busy, done, tmo, errflg;
    logic [EW-1:0] errcntr;
    logic          rd_en, flip_all, flip_one;
    logic [W-1:0]  flip_word;

    int n_vec = 0;
    int n_err = 0;
    logic [W-1:0] exp_q[$];

    always #5 clk = ~clk;

    // Wire-style DUT with optional bit0 corruption on the read side
    assign wrrdy  = rdrdy;
    assign rdvld  = wrvld & rd_en;
    assign rddata = wrdata ^ ((flip_all || (flip_one && wrdata == flip_word)) ? W'(1) : W'(0));

    proj_lane_gen_chk #(
        .W(W), .CW(CW), .EW(EW), .X(1), .SEED(4'h9), .TO(TO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mode(mode), .len(len),
        .wrdata(wrdata), .wrvld(wrvld), .wrrdy(wrrdy),
        .rddata(rddata), .rdvld(rdvld), .rdrdy(rdrdy),
        .busy(busy), .done(done), .tmo(tmo),
        .errcntr(errcntr), .errflg(errflg), .errexp(errexp), .erract(erract)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", name, act, req);
        end
    endtask

    // Monitor: every accepted generator word must match the next expected word
    always @(negedge clk) begin
        if (!rst && wrvld && wrrdy) begin
            if (exp_q.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL wrdata_extra: got %0h want none", wrdata);
            end else begin
                check("wrdata", 32'(wrdata), 32'(exp_q.pop_front()));
            end
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic run_start(input logic [1:0] m, input logic [CW-1:0] l);
        mode  = m;
        len   = l;
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic push(input logic [W-1:0] v);
        exp_q.push_back(v);
    endtask

    task automatic wait_done(input string name, output int busy_cyc);
        int n;
        n = 0;
        busy_cyc = 0;
        while (n < 2000) begin
            @(negedge clk);
            if (done) break;
            if (busy) busy_cyc++;
            n++;
        end
        if (!done) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_timeout: done=0 want 1", name);
        end
    endtask

    initial begin
        int bc;
        int k;
        rst = 1'b1; start = 1'b0; stop = 1'b0; mode = 2'd0; len = '0;
        rd_en = 1'b1; flip_all = 1'b0; flip_one = 1'b0; flip_word = '0;
        tick(3);
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_wrvld", wrvld, 0);
        check("rst_rdrdy", rdrdy, 0);
        check("rst_tmo", tmo, 0);
        check("rst_errcntr", errcntr, 0);
        check("rst_errflg", errflg, 0);
        check("rst_wrdata", wrdata, 0);
        check("rst_errexp", errexp, 0);
        check("rst_erract", erract, 0);
        tick();
        rst = 1'b0;

        // 1: counter, len 8, clean wire
        for (int i = 0; i < 8; i++) push(W'(i));
        run_start(2'd0, 16'd8);
        wait_done("t1", bc);
        check("t1_busy_cycles", bc, 9);
        check("t1_errcntr", errcntr, 0);
        check("t1_tmo", tmo, 0);
        check("t1_q_empty", exp_q.size(), 0);

        // 2: walking one wraps at W=4
        push(4'h1); push(4'h2); push(4'h4); push(4'h8); push(4'h1); push(4'h2);
        tick();
        run_start(2'd2, 16'd6);
        wait_done("t2", bc);
        check("t2_busy_cycles", bc, 7);
        check("t2_errflg", errflg, 0);
        check("t2_q_empty", exp_q.size(), 0);

        // 3: bit0 of word 2 flipped
        for (int i = 0; i < 4; i++) push(W'(i));
        flip_one = 1'b1; flip_word = 4'h2;
        tick();
        run_start(2'd0, 16'd4);
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(rdvld && rdrdy && wrdata == 4'h2) && k < 50);
        check("t3_beat_seen", (k < 50), 1);
        check("t3_errflg_during", errflg, 0);
        @(negedge clk);
        check("t3_errflg_after", errflg, 1);
        wait_done("t3", bc);
        check("t3_errcntr", errcntr, 1);
        check("t3_errexp", errexp, 2);
        check("t3_erract", erract, 3);
        flip_one = 1'b0;

        // 4: continuous, no reads, stop at cycle 10 -> drain timeout
        for (int i = 0; i < 10; i++) push(W'(i));
        rd_en = 1'b0;
        tick();
        run_start(2'd0, 16'd0);
        tick(9);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_done("t4", bc);
        check("t4_drain_cycles", bc, TO);
        check("t4_tmo", tmo, 1);
        check("t4_errcntr", errcntr, 0);
        check("t4_q_empty", exp_q.size(), 0);
        rd_en = 1'b1;

        // 5: every word corrupted, counter saturates at 3
        for (int i = 0; i < 10; i++) push(W'(i));
        flip_all = 1'b1;
        tick();
        run_start(2'd0, 16'd10);
        wait_done("t5", bc);
        check("t5_errcntr", errcntr, 3);
        check("t5_errexp", errexp, 0);
        check("t5_erract", erract, 1);
        check("t5_errflg", errflg, 1);
        check("t5_tmo", tmo, 0);
        check("t5_q_empty", exp_q.size(), 0);
        flip_all = 1'b0;

        // 6: reset during beat 3, then LFSR rerun from SEED
        push(4'h0); push(4'h1);
        tick();
        run_start(2'd0, 16'd10);
        tick(2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_wrvld", wrvld, 0);
        check("t6_rdrdy", rdrdy, 0);
        check("t6_errcntr", errcntr, 0);
        check("t6_wrdata", wrdata, 0);
        check("t6_q_empty_pre", exp_q.size(), 0);
        push(4'h9); push(4'hB); push(4'hF); push(4'h7);
        tick();
        run_start(2'd1, 16'd4);
        wait_done("t6", bc);
        check("t6_errcntr_run", errcntr, 0);
        check("t6_tmo", tmo, 0);
        check("t6_q_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
